// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller and the forwarding unit.
// Holds the sequencer state encoding and the default register-index width.
package hazard_pkg;

    localparam int DEFAULT_SRC_LENGTH = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazard_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard compare between the ID sources and the EXE/MEM destinations.
// With forwarding only a load in EXE stalls; without it any pending write in EXE or MEM does.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int SRC_W = DEFAULT_SRC_LENGTH
) (
    input  logic             i_fwd_en,
    input  logic [SRC_W-1:0] i_src1_ID,
    input  logic [SRC_W-1:0] i_src2_ID,
    input  logic             i_two_src_ID,
    input  logic [SRC_W-1:0] i_dest_EXE,
    input  logic [SRC_W-1:0] i_dest_MEM,
    input  logic             i_WB_EN_EXE,
    input  logic             i_WB_EN_MEM,
    input  logic             i_MEM_R_EN_EXE,
    output logic             o_hazard
);

    logic w_match_exe;
    logic w_match_mem;

    // Register 0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic f_match(input logic [SRC_W-1:0] src1,
                                     input logic [SRC_W-1:0] src2,
                                     input logic             two_src,
                                     input logic [SRC_W-1:0] dest);
        return (dest != '0) && ((src1 == dest) || (two_src && (src2 == dest)));
    endfunction

    assign w_match_exe = f_match(i_src1_ID, i_src2_ID, i_two_src_ID, i_dest_EXE);
    assign w_match_mem = f_match(i_src1_ID, i_src2_ID, i_two_src_ID, i_dest_MEM);

    assign o_hazard = i_fwd_en
                    ? (i_MEM_R_EN_EXE & i_WB_EN_EXE & w_match_exe)
                    : ((i_WB_EN_EXE & w_match_exe) | (i_WB_EN_MEM & w_match_mem));

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: load-use bubbles, branch flush, SRAM-wait freeze with timeout,
// plus a sticky memory error and a saturating stall-cycle counter.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int SRC_LENGTH = DEFAULT_SRC_LENGTH,
    parameter int MAX_WAIT   = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fwd_en,
    input  logic [SRC_LENGTH-1:0] src1_ID,
    input  logic [SRC_LENGTH-1:0] src2_ID,
    input  logic                  two_src_ID,
    input  logic [SRC_LENGTH-1:0] dest_EXE,
    input  logic [SRC_LENGTH-1:0] dest_MEM,
    input  logic                  WB_EN_EXE,
    input  logic                  WB_EN_MEM,
    input  logic                  MEM_R_EN_EXE,
    input  logic                  mem_access_MEM,
    input  logic                  sram_ready,
    input  logic                  branch_taken_EXE,
    output logic                  freeze_front,
    output logic                  bubble_EXE,
    output logic                  freeze_pipe,
    output logic                  flush,
    output logic                  mem_error,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int WAIT_W = $clog2(MAX_WAIT) + 1;
    localparam logic [1:0] S_RUN      = RUN;
    localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
    localparam logic [1:0] S_ERROR    = ERROR;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_hazard;
    logic              w_mem_busy;
    logic              w_in_error;
    logic              w_freeze_front;
    logic              w_bubble;
    logic              w_freeze_pipe;
    logic              w_flush;

    hazard_detect #(.SRC_W(SRC_LENGTH)) u_detect (
        .i_fwd_en       (fwd_en),
        .i_src1_ID      (src1_ID),
        .i_src2_ID      (src2_ID),
        .i_two_src_ID   (two_src_ID),
        .i_dest_EXE     (dest_EXE),
        .i_dest_MEM     (dest_MEM),
        .i_WB_EN_EXE    (WB_EN_EXE),
        .i_WB_EN_MEM    (WB_EN_MEM),
        .i_MEM_R_EN_EXE (MEM_R_EN_EXE),
        .o_hazard       (w_hazard)
    );

    assign w_mem_busy = mem_access_MEM & ~sram_ready;
    assign w_in_error = (r_state == S_ERROR);

    // A branch seen during a memory freeze waits in EXE and flushes once the freeze lifts.
    always_comb begin
        w_freeze_front = 1'b0;
        w_bubble       = 1'b0;
        w_freeze_pipe  = 1'b0;
        w_flush        = 1'b0;
        if (w_in_error || w_mem_busy) begin
            w_freeze_pipe = 1'b1;
        end else if (branch_taken_EXE) begin
            w_flush = 1'b1;
        end else if (w_hazard) begin
            w_freeze_front = 1'b1;
            w_bubble       = 1'b1;
        end
        if (rst) begin
            w_freeze_front = 1'b0;
            w_bubble       = 1'b0;
            w_freeze_pipe  = 1'b0;
            w_flush        = 1'b0;
        end
    end

    // Unused encoding 3 behaves exactly like RUN.
    always_comb begin
        w_state_nxt = S_RUN;
        case (r_state)
            S_MEM_WAIT: begin
                if (!w_mem_busy)                   w_state_nxt = S_RUN;
                else if (r_wait_cnt == WAIT_LAST)  w_state_nxt = S_ERROR;
                else                               w_state_nxt = S_MEM_WAIT;
            end
            S_ERROR:   w_state_nxt = S_ERROR;
            default:   w_state_nxt = w_mem_busy ? S_MEM_WAIT : S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= (r_state == S_MEM_WAIT) ? r_wait_cnt + 1'b1 : '0;
            if ((w_freeze_pipe || w_bubble) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign freeze_front = w_freeze_front;
    assign bubble_EXE   = w_bubble;
    assign freeze_pipe  = w_freeze_pipe;
    assign flush        = w_flush;
    assign mem_error    = w_in_error;
    assign state        = r_state;
    assign stall_cycles = r_stall_cnt;

endmodule
